trdb_trace_ctrl: RTL and testbench

TRDB_TRACE_CTRL -- requirements
Module: trdb_trace_ctrl

---
 rtl/trdb_trace_ctrl.sv | 120 ++++++++++++
 tb/tb_trdb_trace_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_trace_ctrl.sv
// Trace control FSM: gates the encoder datapath and sequences
// start/stop packet requests, drain wait and overflow reporting.
module trdb_trace_ctrl #(
    parameter int unsigned DRAIN_MAX = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       activate_i,
    input  logic       trace_req_on_i,
    input  logic       trace_req_off_i,
    input  logic       encap_ready_i,
    input  logic       pkt_busy_i,
    input  logic       pkt_ack_i,
    output logic       trace_enable_o,
    output logic       start_pkt_req_o,
    output logic       stop_pkt_req_o,
    output logic       overflow_o,
    output logic       drain_timeout_o,
    output logic [2:0] state_o
);

    localparam int unsigned CW = $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(DRAIN_MAX);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        TRACE = 3'd3,
        STOP  = 3'd4,
        DRAIN = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_prev_q, off_prev_q;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;
    logic          on_edge, off_edge;

    assign on_edge  = trace_req_on_i & ~on_prev_q;
    assign off_edge = trace_req_off_i & ~off_prev_q;

    // Next-state logic; deactivation overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ovf_d   = ovf_q;
        tmo_d   = 1'b0;
        if (!activate_i) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF: state_d = IDLE;
                IDLE: begin
                    if (on_edge && !off_edge && encap_ready_i) begin
                        state_d = START;
                        ovf_d   = 1'b0;
                    end
                end
                START: begin
                    if (pkt_ack_i) state_d = TRACE;
                end
                TRACE: begin
                    if (!encap_ready_i) begin
                        state_d = STOP;
                        ovf_d   = 1'b1;
                    end else if (off_edge) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (pkt_ack_i) state_d = DRAIN;
                end
                DRAIN: begin
                    if (!pkt_busy_i) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        tmo_d   = 1'b1;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // State, drain counter, request edge history and flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            on_prev_q  <= 1'b0;
            off_prev_q <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            on_prev_q  <= trace_req_on_i;
            off_prev_q <= trace_req_off_i;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    assign trace_enable_o  = (state_q == START) || (state_q == TRACE) ||
                             (state_q == STOP);
    assign start_pkt_req_o = (state_q == START);
    assign stop_pkt_req_o  = (state_q == STOP);
    assign overflow_o      = ovf_q;
    assign drain_timeout_o = tmo_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Bench for trdb_trace_ctrl: behavioural model compared every cycle
// plus literal expectations for the directed scenarios.
module tb_trdb_trace_ctrl;

    localparam int DM = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       act, on, off, rdy, busy, ack;
    logic       ten, sreq, preq, ovf, tmo;
    logic [2:0] st;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 0;
    bit log_en = 0;
    int st_log[$];
    int ten_log[$];

    // model state
    int m_st, m_dcyc;
    bit m_onp, m_offp, m_ovf, m_tmo;

    trdb_trace_ctrl #(.DRAIN_MAX(DM)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .activate_i      (act),
        .trace_req_on_i  (on),
        .trace_req_off_i (off),
        .encap_ready_i   (rdy),
        .pkt_busy_i      (busy),
        .pkt_ack_i       (ack),
        .trace_enable_o  (ten),
        .start_pkt_req_o (sreq),
        .stop_pkt_req_o  (preq),
        .overflow_o      (ovf),
        .drain_timeout_o (tmo),
        .state_o         (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int a, input int e);
        n_chk++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, a, e, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: states as plain numbers, drain measured
    // as number of DRAIN cycles elapsed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_dcyc = 0; m_onp = 0; m_offp = 0;
            m_ovf = 0; m_tmo = 0;
        end else begin
            bit on_e, off_e;
            on_e = on && !m_onp;
            off_e = off && !m_offp;
            m_onp = on;
            m_offp = off;
            m_tmo = 0;
            if (!act) begin
                m_st = 0;
                m_dcyc = 0;
            end else if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 1) begin
                if (on_e && !off_e && rdy) begin
                    m_st = 2;
                    m_ovf = 0;
                end
            end else if (m_st == 2) begin
                if (ack) m_st = 3;
            end else if (m_st == 3) begin
                if (!rdy) begin
                    m_st = 4;
                    m_ovf = 1;
                end else if (off_e) m_st = 4;
            end else if (m_st == 4) begin
                if (ack) begin
                    m_st = 5;
                    m_dcyc = 0;
                end
            end else begin
                m_dcyc++;
                if (!busy) m_st = 1;
                else if (m_dcyc == DM) begin
                    m_st = 1;
                    m_tmo = 1;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", st, m_st);
            chk("trace_en", ten, int'(m_st >= 2 && m_st <= 4));
            chk("start_req", sreq, int'(m_st == 2));
            chk("stop_req", preq, int'(m_st == 4));
            chk("overflow", ovf, m_ovf);
            chk("timeout", tmo, m_tmo);
            chk("req_excl", int'(sreq && preq), 0);
        end
        if (log_en) begin
            st_log.push_back(int'(st));
            ten_log.push_back(int'(ten));
        end
    end

    initial begin
        int exp_st[13] = '{1, 2, 2, 2, 3, 3, 3, 4, 4, 5, 5, 5, 1};
        int exp_te[13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int n_drain, n_to;

        rst_n = 0;
        act = 0; on = 0; off = 0; rdy = 0; busy = 0; ack = 0;
        tick(2);
        chk("rst_state", st, 0);
        chk("rst_outs", {ten, sreq, preq, ovf, tmo}, 0);
        chk_en = 1;
        rst_n = 1;
        tick(2);
        chk("off_hold", st, 0);
        act = 1; rdy = 1; busy = 1;
        tick(1);
        chk("to_idle", st, 1);

        // normal flow
        log_en = 1;
        on = 1;
        tick(1);
        on = 0;
        tick(2);
        ack = 1;
        tick(1);
        ack = 0;
        tick(2);
        off = 1;
        tick(1);
        off = 0;
        tick(1);
        ack = 1;
        tick(1);
        ack = 0;
        tick(2);
        busy = 0;
        tick(1);
        @(negedge clk);
        #1;
        log_en = 0;
        chk("flow_len", st_log.size(), 13);
        if (st_log.size() == 13) begin
            for (int i = 0; i < 13; i++) begin
                chk($sformatf("flow_st[%0d]", i), st_log[i], exp_st[i]);
                chk($sformatf("flow_te[%0d]", i), ten_log[i], exp_te[i]);
            end
        end

        // backpressure
        on = 1;
        tick(1);
        on = 0;
        ack = 1;
        tick(1);
        ack = 0;
        tick(1);
        chk("bp_trace", st, 3);
        rdy = 0;
        tick(1);
        chk("bp_stop", st, 4);
        chk("bp_ovf", ovf, 1);
        rdy = 1;
        ack = 1;
        tick(1);
        ack = 0;
        tick(1);
        chk("bp_idle", st, 1);
        chk("bp_ovf_held", ovf, 1);
        on = 1;
        tick(1);
        on = 0;
        chk("bp_restart", st, 2);
        chk("bp_ovf_clr", ovf, 0);

        // drain timeout
        ack = 1;
        tick(1);
        ack = 0;
        off = 1;
        tick(1);
        off = 0;
        busy = 1;
        ack = 1;
        tick(1);
        ack = 0;
        n_drain = 0;
        n_to = 0;
        for (int i = 0; i < 10; i++) begin
            if (st == 3'd5) n_drain++;
            if (tmo) n_to++;
            tick(1);
        end
        chk("drain_len", n_drain, 4);
        chk("drain_pulses", n_to, 1);
        chk("drain_idle", st, 1);
        busy = 0;

        // coinciding edges
        on = 1; off = 1;
        tick(1);
        chk("coinc_state", st, 1);
        chk("coinc_sreq", sreq, 0);
        on = 0; off = 0;
        tick(1);

        // edge while not ready is dropped
        rdy = 0; on = 1;
        tick(1);
        rdy = 1;
        tick(1);
        chk("norq_state", st, 1);
        on = 0;
        tick(1);

        // deactivation in START
        on = 1;
        tick(1);
        on = 0;
        tick(1);
        chk("deact_start", st, 2);
        act = 0;
        tick(1);
        chk("deact_off", st, 0);
        chk("deact_reqs", {sreq, preq}, 0);
        act = 1;
        tick(1);
        chk("react_idle", st, 1);

        // reset in STOP
        on = 1;
        tick(1);
        on = 0;
        ack = 1;
        tick(1);
        ack = 0;
        off = 1;
        tick(1);
        off = 0;
        chk("rs_stop", st, 4);
        rst_n = 0;
        #1;
        chk("rs_state", st, 0);
        chk("rs_outs", {ten, sreq, preq, ovf, tmo}, 0);
        tick(1);
        rst_n = 1;
        chk("rs_rel_off", st, 0);
        tick(1);
        chk("rs_idle", st, 1);
        chk("rs_no_stop", preq, 0);
        tick(2);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
